// File: rtl/max7219_sequencer_if.sv
// Shifter-side handshake bundle for max7219_sequencer: start/data/busy plus the MAX7219 LOAD/CS line.
interface max7219_sequencer_if;
    logic        spi_start;
    logic [15:0] spi_data;
    logic        spi_busy;
    logic        cs;

    modport master (output spi_start, output spi_data, output cs, input spi_busy);
    modport slave  (input spi_start, input spi_data, input cs, output spi_busy);
endinterface

// File: rtl/max7219_sequencer.sv
// MAX7219 command sequencer: init words, then 8 digit writes per frame through a start/busy shifter.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits (7..1) when the frame snapshot is taken.
module max7219_sequencer #(
    parameter logic [3:0]  INTENSITY   = 4'h8,
    parameter int unsigned GAP_CYCLES  = 2,
    parameter int unsigned ARM_TIMEOUT = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [31:0]                digits_i,
    input  logic                       update_i,
    max7219_sequencer_if.master        spi,
    output logic                       ready_o,
    output logic                       err_o
);

    localparam logic [2:0] S_BOOT  = 3'd0;
    localparam logic [2:0] S_SEND  = 3'd1;
    localparam logic [2:0] S_ARM   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;
    localparam logic [2:0] S_IDLE  = 3'd5;

    localparam int unsigned CNT_MAX = (ARM_TIMEOUT > GAP_CYCLES) ? ARM_TIMEOUT : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    logic [2:0]       sub_q, sub_d;
    logic             frame_q, frame_d;
    logic [2:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      snap_q, snap_d;
    logic             pending_q, pending_d;
    logic             err_q, err_d;
    logic             start_q;
    logic [15:0]      data_q;
    logic             cs_q;
    logic             ready_q;
    logic             advance;
    logic             start_frame;
    logic             last_word;

    function automatic logic [31:0] snapshot(input logic [31:0] d);
        logic [31:0] r;
`ifdef LEADING_ZERO_BLANK_EN
        logic lead;
`endif
        r = d;
`ifdef LEADING_ZERO_BLANK_EN
        lead = 1'b1;
        for (int unsigned i = 7; i >= 1; i--) begin
            if (lead && (r[4*i +: 4] == 4'h0)) r[4*i +: 4] = 4'hF;
            else                                lead = 1'b0;
        end
`endif
        return r;
    endfunction

    function automatic logic [15:0] word_of(input logic in_frame, input logic [2:0] idx,
                                            input logic [31:0] snap);
        logic [15:0] w;
        w = '0;
        if (in_frame) begin
            w = {4'h0, {1'b0, idx} + 4'd1, 4'h0, snap[{idx, 2'b00} +: 4]};
        end else begin
            case (idx)
                3'd0:    w = 16'h0F00;
                3'd1:    w = 16'h09FF;
                3'd2:    w = {8'h0A, 4'h0, INTENSITY};
                3'd3:    w = 16'h0B07;
                default: w = 16'h0C01;
            endcase
        end
        return w;
    endfunction

    always_comb begin
        sub_d       = sub_q;
        frame_d     = frame_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        snap_d      = snap_q;
        pending_d   = pending_q | update_i;
        err_d       = err_q;
        advance     = 1'b0;
        start_frame = 1'b0;
        last_word   = frame_q ? (idx_q == 3'd7) : (idx_q == 3'd4);

        case (sub_q)
            S_BOOT: sub_d = S_SEND;
            S_SEND: begin
                sub_d = S_ARM;
                cnt_d = '0;
            end
            S_ARM: begin
                if (spi.spi_busy) begin
                    sub_d = S_DRAIN;
                end else if (cnt_q == CNT_W'(ARM_TIMEOUT - 1)) begin
                    err_d = 1'b1;
                    sub_d = S_GAP;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                if (!spi.spi_busy) begin
                    sub_d = S_GAP;
                    cnt_d = '0;
                end
            end
            S_GAP: begin
                if (cnt_q == CNT_W'(GAP_CYCLES - 1)) advance = 1'b1;
                else                                  cnt_d = cnt_q + CNT_W'(1);
            end
            S_IDLE: begin
                if (pending_q || update_i) start_frame = 1'b1;
            end
            default: sub_d = S_BOOT;
        endcase

        if (advance) begin
            if (!last_word) begin
                idx_d = idx_q + 3'd1;
                sub_d = S_SEND;
            end else if (pending_q || update_i) begin
                start_frame = 1'b1;
            end else begin
                sub_d = S_IDLE;
            end
        end

        // Frame entry absorbs any update arriving in the same cycle.
        if (start_frame) begin
            frame_d   = 1'b1;
            idx_d     = 3'd0;
            sub_d     = S_SEND;
            snap_d    = snapshot(digits_i);
            pending_d = 1'b0;
        end
    end

    // Outputs are registered from next-state so they line up with the state they describe.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sub_q     <= S_BOOT;
            frame_q   <= 1'b0;
            idx_q     <= 3'd0;
            cnt_q     <= '0;
            snap_q    <= '0;
            pending_q <= 1'b1;
            err_q     <= 1'b0;
            start_q   <= 1'b0;
            data_q    <= '0;
            cs_q      <= 1'b1;
            ready_q   <= 1'b0;
        end else begin
            sub_q     <= sub_d;
            frame_q   <= frame_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            snap_q    <= snap_d;
            pending_q <= pending_d;
            err_q     <= err_d;
            start_q   <= (sub_d == S_SEND);
            cs_q      <= !((sub_d == S_SEND) || (sub_d == S_ARM) || (sub_d == S_DRAIN));
            ready_q   <= (sub_d == S_IDLE);
            if (sub_d == S_SEND) data_q <= word_of(frame_d, idx_d, snap_d);
        end
    end

    assign spi.spi_start = start_q;
    assign spi.spi_data  = data_q;
    assign spi.cs        = cs_q;
    assign ready_o       = ready_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_max7219_sequencer.sv
// Self-checking bench for max7219_sequencer: shifter model plus expected-word scoreboard.
module tb_max7219_sequencer;

    localparam int GAP = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] digits = '0;
    logic        update = 1'b0;
    logic        ready;
    logic        err;

    logic        busy_m = 1'b0;
    bit          shifter_en = 1'b1;
    int          left = 0;
    bit          arm_d = 1'b0;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] expq[$];
    int          cs_run = 0;
    bit          seen_word = 1'b0;
    logic [15:0] last_word = '0;

    max7219_sequencer_if bus ();
    assign bus.spi_busy = busy_m;

    max7219_sequencer #(
        .INTENSITY   (4'h8),
        .GAP_CYCLES  (2),
        .ARM_TIMEOUT (8)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .digits_i (digits),
        .update_i (update),
        .spi      (bus),
        .ready_o  (ready),
        .err_o    (err)
    );

    always #5 clk = ~clk;

    // Shifter model: busy rises one cycle after start and stays high for 64 cycles.
    always @(negedge clk) begin
        if (!shifter_en || rst) begin
            busy_m = 1'b0;
            arm_d  = 1'b0;
            left   = 0;
        end else if (bus.spi_start === 1'b1) begin
            arm_d = 1'b1;
        end else if (arm_d) begin
            arm_d  = 1'b0;
            busy_m = 1'b1;
            left   = 64;
        end else if (left > 0) begin
            left = left - 1;
            if (left == 0) busy_m = 1'b0;
        end
    end

    task automatic step();
        logic [15:0] exp_w;
        @(negedge clk);
        #1;
        if (rst === 1'b0) begin
            if (bus.spi_start === 1'b1) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word: got %h, required no word", bus.spi_data);
                end else begin
                    exp_w = expq.pop_front();
                    if (bus.spi_data !== exp_w) begin
                        errors++;
                        $display("FAIL word: got %h, required %h", bus.spi_data, exp_w);
                    end
                end
                checks++;
                if (bus.cs !== 1'b0) begin
                    errors++;
                    $display("FAIL cs_at_start: got %b, required 0", bus.cs);
                end
                checks++;
                if (ready !== 1'b0) begin
                    errors++;
                    $display("FAIL ready_in_frame: got %b, required 0", ready);
                end
                if (seen_word) begin
                    checks++;
                    if (cs_run < GAP) begin
                        errors++;
                        $display("FAIL cs_gap: got %0d high cycles, required >= %0d", cs_run, GAP);
                    end
                end
                last_word = bus.spi_data;
                seen_word = 1'b1;
                cs_run    = 0;
            end else if (bus.cs === 1'b0) begin
                checks++;
                if (bus.spi_data !== last_word) begin
                    errors++;
                    $display("FAIL data_hold: got %h, required %h", bus.spi_data, last_word);
                end
            end
            if (bus.cs === 1'b1) cs_run++;
            if (busy_m === 1'b1) begin
                checks++;
                if (bus.cs !== 1'b0) begin
                    errors++;
                    $display("FAIL cs_during_shift: got %b, required 0", bus.cs);
                end
            end
        end
    endtask

    task automatic watch(input int max_cycles, input string name);
        int n;
        n = 0;
        while ((expq.size() != 0 || ready !== 1'b1) && n < max_cycles) begin
            step();
            n++;
        end
        checks++;
        if (expq.size() != 0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_done: %0d words outstanding, ready=%b, required 0 words and ready=1",
                     name, expq.size(), ready);
            expq.delete();
        end
        repeat (5) step();
    endtask

    task automatic pulse_update();
        update = 1'b1;
        step();
        update = 1'b0;
    endtask

    task automatic push_init();
        expq.push_back(16'h0F00);
        expq.push_back(16'h09FF);
        expq.push_back(16'h0A08);
        expq.push_back(16'h0B07);
        expq.push_back(16'h0C01);
    endtask

    task automatic push_zero_frame();
        for (int i = 1; i <= 8; i++) begin
`ifdef LEADING_ZERO_BLANK_EN
            expq.push_back((i == 1) ? 16'h0100 : {8'(i), 8'h0F});
`else
            expq.push_back({8'(i), 8'h00});
`endif
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (bus.cs !== 1'b1) begin errors++; $display("FAIL rst_cs: got %b, required 1", bus.cs); end
        checks++; if (bus.spi_start !== 1'b0) begin errors++; $display("FAIL rst_start: got %b, required 0", bus.spi_start); end
        checks++; if (bus.spi_data !== 16'h0000) begin errors++; $display("FAIL rst_data: got %h, required 0000", bus.spi_data); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b, required 0", ready); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b, required 0", err); end
        push_init();
        push_zero_frame();
        seen_word = 1'b0;
        last_word = '0;
        rst = 1'b0;
        watch(3000, "init");
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL init_err: got %b, required 0", err); end
    endtask

    task automatic test_frame();
        digits = 32'h87654321;
        for (int i = 1; i <= 8; i++) expq.push_back({8'(i), 8'(i)});
        pulse_update();
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL ready_drop: got %b, required 0", ready); end
        watch(2000, "frame");
    endtask

    task automatic test_back_to_back();
        logic [15:0] old_exp [8];
        old_exp = '{16'h0107, 16'h0205, 16'h0303, 16'h0401, 16'h0508, 16'h0606, 16'h0704, 16'h0802};
        digits = 32'h24681357;
        for (int i = 0; i < 8; i++) expq.push_back(old_exp[i]);
        for (int i = 1; i <= 8; i++) expq.push_back({8'(i), 8'h01});
        pulse_update();
        repeat (80) step();
        digits = 32'h11111111;
        for (int k = 0; k < 3; k++) begin
            pulse_update();
            repeat (50) step();
        end
        watch(3000, "coalesce");
    endtask

    task automatic test_timeout();
        shifter_en = 1'b0;
        digits = 32'h11111111;
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL err_before_timeout: got %b, required 0", err); end
        for (int i = 1; i <= 8; i++) expq.push_back({8'(i), 8'h01});
        pulse_update();
        checks++;
        if (bus.spi_start !== 1'b1) begin errors++; $display("FAIL timeout_first_start: got %b, required 1", bus.spi_start); end
        repeat (8) step();
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL err_early: got %b, required 0", err); end
        step();
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL err_set: got %b, required 1", err); end
        watch(1000, "timeout");
        shifter_en = 1'b1;
        for (int i = 1; i <= 8; i++) expq.push_back({8'(i), 8'h01});
        pulse_update();
        watch(2000, "after_timeout");
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b, required 1", err); end
    endtask

    task automatic test_rst_mid();
        int n;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        seen_word = 1'b0;
        rst = 1'b0;
        expq.push_back(16'h0F00);
        expq.push_back(16'h09FF);
        expq.push_back(16'h0A08);
        expq.push_back(16'h0B07);
        n = 0;
        while (expq.size() != 0 && n < 1000) begin
            step();
            n++;
        end
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL rst_mid_reach: %0d words outstanding, required 0", expq.size());
            expq.delete();
        end
        repeat (10) step();
        checks++;
        if (bus.cs !== 1'b0) begin errors++; $display("FAIL drain_cs: got %b, required 0", bus.cs); end
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (bus.cs !== 1'b1) begin errors++; $display("FAIL midrst_cs: got %b, required 1", bus.cs); end
        checks++; if (bus.spi_start !== 1'b0) begin errors++; $display("FAIL midrst_start: got %b, required 0", bus.spi_start); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b, required 0", ready); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL midrst_err: got %b, required 0", err); end
        repeat (2) @(negedge clk);
        #1;
        push_init();
        for (int i = 1; i <= 8; i++) expq.push_back({8'(i), 8'h01});
        seen_word = 1'b0;
        rst = 1'b0;
        watch(3000, "restart");
    endtask

    task automatic test_blank();
        digits = 32'h00000120;
        expq.push_back(16'h0100);
        expq.push_back(16'h0202);
        expq.push_back(16'h0301);
        for (int i = 4; i <= 8; i++) begin
`ifdef LEADING_ZERO_BLANK_EN
            expq.push_back({8'(i), 8'h0F});
`else
            expq.push_back({8'(i), 8'h00});
`endif
        end
        pulse_update();
        watch(2000, "blank");
    endtask

    initial begin
        test_reset();
        test_frame();
        test_back_to_back();
        test_timeout();
        test_rst_mid();
        test_blank();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
